// File: rtl/lib_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lib_pkg
// Description : Shared types and constants for the data-memory responder:
//               FSM state encoding, read byte-enable code, counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package lib_pkg;

    // Responder FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // Byte-enable pattern that marks a request as a read
    localparam logic [3:0] DMEM_BE_READ = 4'b0000;

    // Latency counter width; holds RD_LAT-1 for RD_LAT up to 8
    localparam int DMEM_CNT_W = 4;

    // True when a byte-enable pattern requests a store
    function automatic logic dmem_is_write(input logic [3:0] be);
        return (be != DMEM_BE_READ);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_bank.sv
`default_nettype none
// ============================================================================
// Module      : dmem_bank
// Description : Word-organised storage with one write port carrying a
//               per-byte-lane enable and one read port whose word index is
//               registered. Contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_bank #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 8
) (
    input  logic                  clk,
    input  logic [WIDTH/8-1:0]    i_wr_be,
    input  logic [IDX_W-1:0]      i_wr_idx,
    input  logic [WIDTH-1:0]      i_wr_data,
    input  logic                  i_rd_en,
    input  logic [IDX_W-1:0]      i_rd_idx,
    output logic [WIDTH-1:0]      o_rd_data
);

    localparam int c_NUM_LANES = WIDTH / 8;
    localparam int c_DEPTH     = 2 ** IDX_W;

    logic [IDX_W-1:0] r_rd_idx;

    // Capture the read index when a read is accepted; data follows the index
    always_ff @(posedge clk) begin
        if (i_rd_en) begin
            r_rd_idx <= i_rd_idx;
        end
    end

    // Each byte lane is its own array so lanes can be written independently
    generate
        for (genvar g = 0; g < c_NUM_LANES; g++) begin : g_lane
            logic [7:0] r_lane_mem [c_DEPTH];

            // Commit this lane of a store when its enable is set
            always_ff @(posedge clk) begin
                if (i_wr_be[g]) begin
                    r_lane_mem[i_wr_idx] <= i_wr_data[g*8 +: 8];
                end
            end

            assign o_rd_data[g*8 +: 8] = r_lane_mem[r_rd_idx];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/dmem_resp.sv
`default_nettype none
// ============================================================================
// Module      : dmem_resp
// Description : Single-port data-memory responder. Accepts valid/ready
//               requests, commits stores at the accept edge, returns loads
//               after RD_LAT cycles and strobes a one-cycle response.
//               Optional feature macro: DMEM_ALIGN_CHK_EN - flags requests
//               with a non-zero byte offset as misaligned (no store, zero
//               data, rsp_err set in the response cycle).
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_resp
    import lib_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DADDR  = 10,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [DADDR-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    input  logic [3:0]       req_be,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err
);

    localparam int                    c_IDX_W  = DADDR - 2;
    localparam logic [DMEM_CNT_W-1:0] c_LAT_M1 = DMEM_CNT_W'(RD_LAT - 1);

    dmem_state_t             r_state;
    dmem_state_t             w_state_nxt;
    logic [DMEM_CNT_W-1:0]   r_cnt;
    logic [DMEM_CNT_W-1:0]   w_cnt_nxt;
    logic                    r_is_rd;
    logic                    w_is_rd_nxt;

    logic                    w_accept;
    logic                    w_is_write;
    logic                    w_misalign;
    logic                    w_resp_err;
    logic [c_IDX_W-1:0]      w_idx;
    logic [3:0]              w_bank_be;
    logic                    w_bank_rd_en;
    logic [WIDTH-1:0]        w_bank_rdata;

    // ------------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------------
    assign req_ready  = (r_state != WAIT);
    assign w_accept   = req_valid & req_ready;
    assign w_is_write = dmem_is_write(req_be);
    assign w_idx      = req_addr[DADDR-1:2];

`ifdef DMEM_ALIGN_CHK_EN
    logic r_err;

    assign w_misalign = (req_addr[1:0] != 2'b00);

    // Remember whether the accepted request was misaligned until it responds
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= w_misalign;
        end
    end

    assign w_resp_err = (r_state == RESP) & r_err;
`else
    logic w_unused_lsb;

    // Byte offset carries no meaning when the alignment check is absent
    assign w_unused_lsb = ^req_addr[1:0];
    assign w_misalign   = 1'b0;
    assign w_resp_err   = 1'b0;
`endif

    // A store in a reset cycle, or a misaligned store, must never reach memory
    assign w_bank_be    = (w_accept && !reset && w_is_write && !w_misalign)
                          ? req_be : 4'b0000;
    assign w_bank_rd_en = w_accept && !w_is_write;

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    dmem_bank #(
        .WIDTH (WIDTH),
        .IDX_W (c_IDX_W)
    ) u_bank (
        .clk       (clk),
        .i_wr_be   (w_bank_be),
        .i_wr_idx  (w_idx),
        .i_wr_data (req_wdata),
        .i_rd_en   (w_bank_rd_en),
        .i_rd_idx  (w_idx),
        .o_rd_data (w_bank_rdata)
    );

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------

    // Next-state, latency-counter and request-type selection
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_is_rd_nxt = r_is_rd;
        case (r_state)
            IDLE, RESP: begin
                if (w_accept) begin
                    w_is_rd_nxt = !w_is_write;
                    if (w_is_write) begin
                        // Store responds in the cycle right after acceptance
                        w_cnt_nxt   = '0;
                        w_state_nxt = RESP;
                    end else begin
                        w_cnt_nxt   = c_LAT_M1;
                        w_state_nxt = (RD_LAT == 1) ? RESP : WAIT;
                    end
                end else if (r_state == RESP) begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT: begin
                w_cnt_nxt = r_cnt - 1'b1;
                // A count of 1 means the next cycle is the response cycle
                if (r_cnt <= DMEM_CNT_W'(1)) begin
                    w_state_nxt = RESP;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_is_rd_nxt = 1'b0;
            end
        endcase
    end

    // State register; reset discards any read in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_is_rd <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_is_rd <= w_is_rd_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Response
    // ------------------------------------------------------------------------
    assign rsp_valid = (r_state == RESP);
    assign rsp_err   = w_resp_err;
    assign rsp_rdata = (rsp_valid && r_is_rd && !w_resp_err) ? w_bank_rdata
                                                             : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_resp
// Description : Directed self-checking bench for dmem_resp. Three instances
//               with RD_LAT = 1, 4 and 3 share one clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_resp;

    logic        clk = 1'b0;
    logic        reset     [3];
    logic        req_valid [3];
    logic        req_ready [3];
    logic [9:0]  req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_be    [3];
    logic        rsp_valid [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_resp #(.WIDTH(32), .DADDR(10), .RD_LAT(1)) u_lat1 (
        .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

    dmem_resp #(.WIDTH(32), .DADDR(10), .RD_LAT(4)) u_lat4 (
        .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

    dmem_resp #(.WIDTH(32), .DADDR(10), .RD_LAT(3)) u_lat3 (
        .clk(clk), .reset(reset[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_be(req_be[2]),
        .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic v, input logic [9:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        req_valid[k] = v;
        req_addr[k]  = a;
        req_wdata[k] = d;
        req_be[k]    = be;
    endtask

    task automatic idle(input int k);
        drive(k, 1'b0, 10'h000, 32'h0, 4'b0000);
    endtask

    // Full-word store, then return to IDLE
    task automatic wr(input int k, input logic [9:0] a, input logic [31:0] d);
        drive(k, 1'b1, a, d, 4'b1111);
        tick();
        idle(k);
        tick();
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            reset[k] = 1'b1;
            idle(k);
        end
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rsp_valid[k] !== 1'b0 || rsp_rdata[k] !== 32'h0 || rsp_err[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs inst=%0d valid=%b rdata=%h err=%b expected 0/0/0",
                         k, rsp_valid[k], rsp_rdata[k], rsp_err[k]);
            end
            checks++;
            if (req_ready[k] !== 1'b1) begin
                errors++;
                $display("FAIL reset_ready inst=%0d got=%b expected=1", k, req_ready[k]);
            end
            reset[k] = 1'b0;
        end
        tick();
    endtask

    task automatic test_write_read();
        drive(0, 1'b1, 10'h010, 32'hDEADBEEF, 4'b1111);
        tick();
        checks++;
        if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'h0 || rsp_err[0] !== 1'b0) begin
            errors++;
            $display("FAIL write_rsp valid=%b rdata=%h err=%b expected 1/00000000/0",
                     rsp_valid[0], rsp_rdata[0], rsp_err[0]);
        end
        idle(0);
        tick();
        checks++;
        if (rsp_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL write_rsp_one_cycle valid=%b expected=0", rsp_valid[0]);
        end
        drive(0, 1'b1, 10'h010, 32'h0, 4'b0000);
        tick();
        checks++;
        if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read_lat1 valid=%b rdata=%h expected 1/deadbeef",
                     rsp_valid[0], rsp_rdata[0]);
        end
        idle(0);
        tick();
        checks++;
        if (rsp_valid[0] !== 1'b0 || rsp_rdata[0] !== 32'h0) begin
            errors++;
            $display("FAIL idle_after_read valid=%b rdata=%h expected 0/00000000",
                     rsp_valid[0], rsp_rdata[0]);
        end
    endtask

    task automatic test_byte_lane();
        wr(0, 10'h020, 32'h11223344);
        drive(0, 1'b1, 10'h020, 32'h0000AA00, 4'b0010);
        tick();
        // Read of the same word held back-to-back behind the partial store
        drive(0, 1'b1, 10'h020, 32'h0, 4'b0000);
        tick();
        idle(0);
        checks++;
        if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'h1122AA44) begin
            errors++;
            $display("FAIL byte_lane_merge valid=%b rdata=%h expected 1/1122aa44",
                     rsp_valid[0], rsp_rdata[0]);
        end
        tick();
    endtask

    task automatic test_latency4();
        wr(1, 10'h004, 32'h55AA0FF0);
        checks++;
        if (req_ready[1] !== 1'b1) begin
            errors++;
            $display("FAIL lat4_ready_c0 got=%b expected=1", req_ready[1]);
        end
        drive(1, 1'b1, 10'h004, 32'h0, 4'b0000);
        tick();
        idle(1);
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (req_ready[1] !== 1'b0 || rsp_valid[1] !== 1'b0 || rsp_rdata[1] !== 32'h0) begin
                errors++;
                $display("FAIL lat4_wait cycle=%0d ready=%b valid=%b rdata=%h expected 0/0/0",
                         c, req_ready[1], rsp_valid[1], rsp_rdata[1]);
            end
            tick();
        end
        checks++;
        if (rsp_valid[1] !== 1'b1 || req_ready[1] !== 1'b1 || rsp_rdata[1] !== 32'h55AA0FF0) begin
            errors++;
            $display("FAIL lat4_resp valid=%b ready=%b rdata=%h expected 1/1/55aa0ff0",
                     rsp_valid[1], req_ready[1], rsp_rdata[1]);
        end
        tick();
        checks++;
        if (rsp_valid[1] !== 1'b0) begin
            errors++;
            $display("FAIL lat4_after valid=%b expected=0", rsp_valid[1]);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0]  addrs [3];
        logic [31:0] datas [3];
        addrs[0] = 10'h040; datas[0] = 32'hA0A0A0A0;
        addrs[1] = 10'h044; datas[1] = 32'hB1B1B1B1;
        addrs[2] = 10'h048; datas[2] = 32'hC2C2C2C2;
        for (int i = 0; i < 3; i++) wr(0, addrs[i], datas[i]);
        drive(0, 1'b1, addrs[0], 32'h0, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i < 2) drive(0, 1'b1, addrs[i+1], 32'h0, 4'b0000);
            else       idle(0);
            checks++;
            if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== datas[i]) begin
                errors++;
                $display("FAIL b2b_read idx=%0d valid=%b rdata=%h expected 1/%h",
                         i, rsp_valid[0], rsp_rdata[0], datas[i]);
            end
        end
        tick();
        checks++;
        if (rsp_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end valid=%b expected=0", rsp_valid[0]);
        end
    endtask

    task automatic test_reset_mid_read();
        int seen = 0;
        wr(2, 10'h008, 32'h0BADF00D);
        drive(2, 1'b1, 10'h008, 32'h0, 4'b0000);
        tick();
        idle(2);
        reset[2] = 1'b1;
        if (rsp_valid[2] !== 1'b0) seen++;
        tick();
        reset[2] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (rsp_valid[2] !== 1'b0) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_drop_read valid_cycles=%0d expected=0", seen);
        end
        checks++;
        if (req_ready[2] !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_after got=%b expected=1", req_ready[2]);
        end
        drive(2, 1'b1, 10'h008, 32'h0, 4'b0000);
        tick();
        idle(2);
        tick();
        checks++;
        if (rsp_valid[2] !== 1'b0) begin
            errors++;
            $display("FAIL lat3_early valid=%b expected=0", rsp_valid[2]);
        end
        tick();
        checks++;
        if (rsp_valid[2] !== 1'b1 || rsp_rdata[2] !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL lat3_after_reset valid=%b rdata=%h expected 1/0badf00d",
                     rsp_valid[2], rsp_rdata[2]);
        end
        tick();
    endtask

    task automatic test_reset_write_block();
        reset[0] = 1'b1;
        drive(0, 1'b1, 10'h010, 32'hFFFFFFFF, 4'b1111);
        tick();
        idle(0);
        reset[0] = 1'b0;
        tick();
        drive(0, 1'b1, 10'h010, 32'h0, 4'b0000);
        tick();
        idle(0);
        checks++;
        if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_in_reset valid=%b rdata=%h expected 1/deadbeef",
                     rsp_valid[0], rsp_rdata[0]);
        end
        tick();
    endtask

    task automatic test_align();
        logic        exp_err;
        logic [31:0] exp_word;
`ifdef DMEM_ALIGN_CHK_EN
        exp_err  = 1'b1;
        exp_word = 32'hDEADBEEF;
`else
        exp_err  = 1'b0;
        exp_word = 32'h12345678;
`endif
        drive(0, 1'b1, 10'h012, 32'h12345678, 4'b1111);
        tick();
        idle(0);
        checks++;
        if (rsp_valid[0] !== 1'b1 || rsp_err[0] !== exp_err || rsp_rdata[0] !== 32'h0) begin
            errors++;
            $display("FAIL align_write valid=%b err=%b rdata=%h expected 1/%b/00000000",
                     rsp_valid[0], rsp_err[0], rsp_rdata[0], exp_err);
        end
        tick();
        drive(0, 1'b1, 10'h010, 32'h0, 4'b0000);
        tick();
        idle(0);
        checks++;
        if (rsp_valid[0] !== 1'b1 || rsp_err[0] !== 1'b0 || rsp_rdata[0] !== exp_word) begin
            errors++;
            $display("FAIL align_word valid=%b err=%b rdata=%h expected 1/0/%h",
                     rsp_valid[0], rsp_err[0], rsp_rdata[0], exp_word);
        end
        tick();
`ifdef DMEM_ALIGN_CHK_EN
        drive(0, 1'b1, 10'h011, 32'h0, 4'b0000);
        tick();
        idle(0);
        checks++;
        if (rsp_valid[0] !== 1'b1 || rsp_err[0] !== 1'b1 || rsp_rdata[0] !== 32'h0) begin
            errors++;
            $display("FAIL align_read valid=%b err=%b rdata=%h expected 1/1/00000000",
                     rsp_valid[0], rsp_err[0], rsp_rdata[0]);
        end
        tick();
`endif
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            reset[k] = 1'b1;
            idle(k);
        end
        test_reset();
        test_write_read();
        test_byte_lane();
        test_latency4();
        test_back_to_back();
        test_reset_mid_read();
        test_reset_write_block();
        test_align();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data word width in bits; only 32 is supported.
REQ-002 SHALL have parameter DADDR, default 10: byte-address width; storage depth is 2**(DADDR-2) words.
REQ-003 SHALL have parameter RD_LAT, default 1: read latency in cycles; legal range is 1..8.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1: reset that is synchronous and active-high.
REQ-006 SHALL have port req_valid, input, 1: a request is present.
REQ-007 SHALL have port req_ready, output, 1: the responder can accept a request this cycle.
REQ-008 SHALL have port req_addr, input, DADDR: byte address.
REQ-009 SHALL have port req_wdata, input, WIDTH: store data, lane-aligned.
REQ-010 SHALL have port req_be, input, 4: byte-lane write enables; 0000 means read.
REQ-011 SHALL have port rsp_valid, output, 1: one-cycle response strobe.
REQ-012 SHALL have port rsp_rdata, output, WIDTH: read data, valid only while rsp_valid is high.
REQ-013 SHALL have port rsp_err, output, 1: misaligned-access flag, valid only while rsp_valid is high.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-015 SHALL drive req_ready high in IDLE and RESP, and low in WAIT.
REQ-016 SHALL accept a request in any cycle where req_valid and req_ready are both high; this is cycle 0.
REQ-017 SHALL select the word index as req_addr[DADDR-1:2].
REQ-018 SHALL, on an accepted write (req_be != 0), update only the enabled byte lanes at the accept edge, then enter RESP; rsp_valid is high in cycle 1 and rsp_rdata = 0.
REQ-019 SHALL, on an accepted read, latch the word index and load the latency counter with RD_LAT-1.
REQ-020 SHALL, on an accepted read, enter RESP directly if RD_LAT = 1, otherwise enter WAIT.
REQ-021 SHALL, in WAIT, decrement the counter each cycle and move to RESP when the counter reaches 1.
REQ-022 SHALL drive rsp_valid high for exactly one cycle, cycle RD_LAT, with rsp_rdata equal to the stored word.
REQ-023 SHALL, from RESP, return to IDLE if no request is accepted, or process a request accepted in RESP exactly as one accepted in IDLE (back-to-back).
REQ-024 SHALL return, on a read issued after a write to the same word, the merged post-write data (no stale read).
REQ-025 SHALL drive rsp_valid low and rsp_rdata = 0 in every cycle outside RESP.

Reset
REQ-026 SHALL, while reset is high, set state = IDLE, counter = 0, rsp_valid = 0, rsp_rdata = 0 and rsp_err = 0 at the next edge.
REQ-027 SHALL, when reset is asserted mid-read, drop the pending read with no response.
REQ-028 SHALL NOT commit a write presented in a cycle where reset is high.
REQ-029 SHALL NOT reset storage contents.

Configuration
REQ-030 SHALL, with macro DMEM_ALIGN_CHK_EN defined, treat any request with req_addr[1:0] != 0 as misaligned: no storage update, response timing per REQ-018/REQ-022, rsp_err = 1 and rsp_rdata = 0 in the response cycle.
REQ-031 SHALL, without DMEM_ALIGN_CHK_EN, ignore req_addr[1:0] and tie rsp_err to 0.

Structure
REQ-032 SHALL define the enum dmem_state_t {IDLE, WAIT, RESP} and the constant DMEM_BE_READ = 4'b0000 in lib_pkg.
REQ-033 SHALL place storage in sub-module dmem_bank: a word array with a per-byte-lane write enable and a registered-index read port.
REQ-034 SHALL keep the FSM, latency counter and alignment check in dmem_resp.

Verification
REQ-035 SHALL verify: RD_LAT=1; write 0xDEADBEEF to 0x010 with be=1111, then read 0x010 -> rsp_valid in cycle 1 of each request; read returns 0xDEADBEEF.
REQ-036 SHALL verify: over a stored word 0x11223344, write 0x0000AA00 with be=0010, then read -> 0x1122AA44.
REQ-037 SHALL verify: RD_LAT=4; read accepted in cycle 0 -> req_ready low in cycles 1..3; rsp_valid high only in cycle 4.
REQ-038 SHALL verify: RD_LAT=1; req_valid held high with 3 consecutive reads -> one response per cycle, no gaps after the first.
REQ-039 SHALL verify: RD_LAT=3; reset pulsed in cycle 1 of a read -> no rsp_valid ever; next request is accepted normally.
REQ-040 SHALL verify: with DMEM_ALIGN_CHK_EN, write to 0x012 -> rsp_err = 1 and the word at 0x010 is unchanged; without the macro, the same write updates word 0x010 and rsp_err = 0.
